// File: rtl/varlat_bank_responder.sv
// varlat_bank_responder: target-side endpoint of the TCDM variable-latency
// protocol. It grants req/gnt requests onto a fixed-latency SRAM macro and
// returns responses on a vld/rdata channel that the consumer may stall.
//
// Ports:
//   clk_i, rst_i                        clock, synchronous active-high reset
//   req_i/add_i/wen_i/wdata_i/be_i      request from crossbar
//   gnt_o                               grant (combinational)
//   vld_o/rdata_o/rsp_ready_i           response channel
//   mem_*_o, mem_rdata_i, mem_ready_i   SRAM macro interface
//
// Build option: define VARLAT_BANK_WRITE_RESP_EN to return one zero-data
// response per granted store (stores then also consume a credit).

module varlat_bank_responder #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddrWidth      = 10,
    parameter int unsigned MemLatency     = 1,
    parameter int unsigned NumOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic [AddrWidth-1:0]   add_i,
    input  logic                   wen_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    output logic                   gnt_o,
    output logic                   vld_o,
    output logic [DataWidth-1:0]   rdata_o,
    input  logic                   rsp_ready_i,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    input  logic                   mem_ready_i
);

    localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);
    localparam int unsigned PtrWidth =
        (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

`ifdef VARLAT_BANK_WRITE_RESP_EN
    localparam logic WrResp = 1'b1;
`else
    localparam logic WrResp = 1'b0;
`endif

    // Pointer layout: {wrap bit, index}; index wraps modulo NumOutstanding.
    typedef logic [PtrWidth:0] ptr_t;

    logic [CntWidth-1:0]   cnt_q;
    logic [MemLatency-1:0] tag_q;
    logic [MemLatency-1:0] we_q;
    ptr_t                  wr_ptr_q;
    ptr_t                  rd_ptr_q;
    bit   [DataWidth-1:0]  fifo_q [NumOutstanding];

    logic                  credit_ok;
    logic                  resp_tag;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic                  full;
    logic [DataWidth-1:0]  push_data;

    function automatic ptr_t ptr_incr(input ptr_t p);
        ptr_t r;
        if (p[PtrWidth-1:0] == PtrWidth'(NumOutstanding - 1)) begin
            r = {~p[PtrWidth], {PtrWidth{1'b0}}};
        end else begin
            r = p + ptr_t'(1);
        end
        return r;
    endfunction

    // Credit is judged on the registered count only, so a pop never
    // re-enables grant in the same cycle (no rsp_ready_i -> gnt_o path).
    assign credit_ok = (cnt_q < CntWidth'(NumOutstanding));
    assign gnt_o     = req_i & mem_ready_i & credit_ok & ~rst_i;

    assign mem_req_o   = gnt_o;
    assign mem_we_o    = wen_i;
    assign mem_addr_o  = add_i;
    assign mem_wdata_o = wdata_i;
    assign mem_be_o    = be_i;

    assign resp_tag  = gnt_o & (~wen_i | WrResp);
    assign push      = tag_q[MemLatency-1];
    assign push_data = we_q[MemLatency-1] ? '0 : mem_rdata_i;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrWidth-1:0] == rd_ptr_q[PtrWidth-1:0]) &&
                   (wr_ptr_q[PtrWidth] != rd_ptr_q[PtrWidth]);

    // Gated by reset so the channel is quiet while rst_i is high.
    assign vld_o   = ~empty & ~rst_i;
    assign pop     = vld_o & rsp_ready_i;
    assign rdata_o = vld_o ? fifo_q[rd_ptr_q[PtrWidth-1:0]] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_q    <= '0;
            we_q     <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            tag_q <= (tag_q << 1) | MemLatency'(resp_tag);
            we_q  <= (we_q << 1) | MemLatency'(wen_i);
            unique case ({resp_tag, pop})
                2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (push) begin
                wr_ptr_q <= ptr_incr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_incr(rd_ptr_q);
            end
        end
    end

    // Storage is deliberately not reset; only the pointers define content.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q[PtrWidth-1:0]] <= push_data;
        end
    end

`ifndef SYNTHESIS
    a_params: assert property (@(posedge clk_i)
        (MemLatency >= 1) && (MemLatency <= 4) &&
        (NumOutstanding >= MemLatency));

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        push |-> !full);

    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        pop |-> !empty);

    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (req_i && !gnt_o) |=>
            (req_i && $stable({add_i, wen_i, wdata_i, be_i})));
`endif

endmodule

// File: tb/tb_varlat_bank_responder.sv
// Directed testbench for varlat_bank_responder (MemLatency=1,
// NumOutstanding=4) with a behavioural single-cycle SRAM model.

module tb_varlat_bank_responder;

`ifdef VARLAT_BANK_WRITE_RESP_EN
    localparam bit WR = 1'b1;
`else
    localparam bit WR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [9:0]  addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        vld;
    logic [31:0] rdata;
    logic        rsp_ready;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    varlat_bank_responder #(
        .DataWidth(32), .AddrWidth(10),
        .MemLatency(1), .NumOutstanding(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(addr),
        .wen_i(wen), .wdata_i(wdata), .be_i(be), .gnt_o(gnt),
        .vld_o(vld), .rdata_o(rdata), .rsp_ready_i(rsp_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
        .mem_ready_i(mem_ready)
    );

    bit [31:0] mem [1024];
    bit [31:0] rd_q;
    assign mem_rdata = rd_q;

    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                rd_q <= mem[mem_addr];
            end
        end
    end

    typedef struct {
        bit        rst;
        bit        req;
        bit        wen;
        bit [9:0]  addr;
        bit [31:0] wdata;
        bit [3:0]  be;
        bit        mrdy;
        bit        rrdy;
        bit        egnt;
        bit        evld;
        bit [31:0] erd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit rq, input bit w,
                       input bit [9:0] a, input bit [31:0] d,
                       input bit [3:0] b, input bit mr, input bit rr,
                       input bit eg, input bit ev, input bit [31:0] ed);
        vec_t v;
        v.rst = r; v.req = rq; v.wen = w; v.addr = a; v.wdata = d;
        v.be = b; v.mrdy = mr; v.rrdy = rr;
        v.egnt = eg; v.evld = ev; v.erd = ed;
        tbl.push_back(v);
    endtask

    task automatic ld(input bit [9:0] a, input bit rr,
                      input bit eg, input bit ev, input bit [31:0] ed);
        add(0, 1, 0, a, 32'h0, 4'hF, 1, rr, eg, ev, ed);
    endtask

    task automatic st(input bit [9:0] a, input bit [31:0] d,
                      input bit [3:0] b, input bit ev, input bit [31:0] ed);
        add(0, 1, 1, a, d, b, 1, 1, 1, ev, ed);
    endtask

    task automatic idle(input bit ev, input bit [31:0] ed);
        add(0, 0, 0, 10'h0, 32'h0, 4'h0, 1, 1, 0, ev, ed);
    endtask

    // Drive at the falling edge, compare 1 ns later.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rst; req = v.req; wen = v.wen; addr = v.addr;
        wdata = v.wdata; be = v.be; mem_ready = v.mrdy;
        rsp_ready = v.rrdy;
        #1;
        chk({tag, ".gnt"}, 32'(gnt), 32'(v.egnt));
        chk({tag, ".mem_req"}, 32'(mem_req), 32'(v.egnt));
        chk({tag, ".vld"}, 32'(vld), 32'(v.evld));
        chk({tag, ".rdata"}, rdata, v.evld ? v.erd : 32'h0);
    endtask

    localparam bit [31:0] DB = 32'hDEADBEEF;
    localparam bit [31:0] MX = 32'hFF22FF44;

    initial begin
        vec_t h;
        int   n;

        rst = 1; req = 0; wen = 0; addr = '0; wdata = '0; be = '0;
        mem_ready = 1; rsp_ready = 1;

        // reset state, request pending during reset
        add(1, 1, 0, 10'h4, 0, 4'hF, 1, 1, 0, 0, 0);
        add(1, 1, 0, 10'h4, 0, 4'hF, 1, 1, 0, 0, 0);
        // store / load / byte enables
        st(10'h4, DB, 4'hF, 0, 0);
        ld(10'h4, 1, 1, 0, 0);
        st(10'h8, 32'hFFFFFFFF, 4'hF, WR, 0);
        st(10'h8, 32'h11223344, 4'h5, 1, DB);
        ld(10'h8, 1, 1, WR, 0);
        idle(WR, 0);
        idle(1, MX);
        idle(0, 0);
        // bank stall for 3 cycles, then a single grant
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 10'h4, 0, 4'hF, 0, 1, 0, 0, 0);
        ld(10'h4, 1, 1, 0, 0);
        idle(0, 0);
        idle(1, DB);
        idle(0, 0);
        // credit exhaustion with a stalled consumer
        ld(10'h4, 0, 1, 0, 0);
        ld(10'h8, 0, 1, 0, 0);
        ld(10'h4, 0, 1, 1, DB);
        ld(10'h8, 0, 1, 1, DB);
        ld(10'h4, 0, 0, 1, DB);
        ld(10'h4, 0, 0, 1, DB);
        ld(10'h4, 1, 0, 1, DB);
        ld(10'h4, 1, 1, 1, MX);
        ld(10'h8, 1, 1, 1, DB);
        idle(1, MX);
        idle(1, DB);
        idle(1, MX);
        idle(0, 0);
        // steady state: one grant and one response per cycle
        ld(10'h4, 1, 1, 0, 0);
        ld(10'h8, 1, 1, 0, 0);
        ld(10'h4, 1, 1, 1, DB);
        ld(10'h8, 1, 1, 1, MX);
        ld(10'h4, 1, 1, 1, DB);
        ld(10'h8, 1, 1, 1, MX);
        idle(1, DB);
        idle(1, MX);
        idle(0, 0);
        // lone store: response only when write responses are built in
        st(10'hC, 32'h12345678, 4'hF, 0, 0);
        idle(0, 0);
        idle(WR, 0);
        idle(0, 0);

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        // reset with two reads in flight: nothing stale may emerge
        h = '{0, 1, 0, 10'h4, 0, 4'hF, 1, 1, 1, 0, 0};
        apply(h, "rst_h0");
        h.addr = 10'h8;
        apply(h, "rst_h1");
        h = '{1, 1, 0, 10'h4, 0, 4'hF, 1, 1, 0, 0, 0};
        apply(h, "rst_h2");
        h.rst = 0; h.egnt = 1;
        apply(h, "rst_h3");
        h = '{0, 0, 0, 10'h0, 0, 4'h0, 1, 1, 0, 0, 0};
        apply(h, "rst_h4");
        h.evld = 1; h.erd = DB;
        apply(h, "rst_h5");
        h.evld = 0; h.erd = 0;
        apply(h, "rst_h6");

        // bounded wait for a response, checking load-to-vld latency
        @(negedge clk);
        req = 1; wen = 0; addr = 10'h8; be = 4'hF;
        #1;
        chk("lat.gnt", 32'(gnt), 32'h1);
        n = 1;
        while (n <= 10) begin
            @(negedge clk);
            req = 0;
            #1;
            if (vld) break;
            n++;
        end
        chk("lat.cycles", 32'(n), 32'd2);
        chk("lat.rdata", rdata, MX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/varlat_bank_responder.md
Name: varlat_bank_responder

Overview:
- Target-side endpoint of the TCDM variable-latency protocol; one instance sits behind each crossbar output port.
- Accepts req/gnt requests and drives a fixed-latency SRAM macro.
- Returns read data, and optionally write acks, on a vld/rdata response channel.
- Latency varies with bank stalls, outstanding-credit exhaustion and response back-pressure; a credit counter plus response FIFO guarantee no response is ever dropped.

Parameters:
- DataWidth, 32, request/response data width in bits.
- AddrWidth, 10, word address width into the bank.
- MemLatency, 1, cycles from mem_req_o to valid mem_rdata_i; legal range 1..4.
- NumOutstanding, 4, maximum responses in flight (memory pipeline + FIFO); also the FIFO depth; must be >= MemLatency.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  1  request valid.
- add_i  in  AddrWidth  word address.
- wen_i  in  1  1: store, 0: load.
- wdata_i  in  DataWidth  write data.
- be_i  in  DataWidth/8  byte enables.
- gnt_o  out  1  grant; combinational on req_i, mem_ready_i and credit.
- vld_o  out  1  response valid.
- rdata_o  out  DataWidth  response data.
- rsp_ready_i  in  1  response consumer ready; tie to 1'b1 if the consumer never stalls.
- mem_req_o  out  1  macro access strobe.
- mem_we_o  out  1  macro write enable.
- mem_addr_o  out  AddrWidth  macro address.
- mem_wdata_o  out  DataWidth  macro write data.
- mem_be_o  out  DataWidth/8  macro byte enables.
- mem_rdata_i  in  DataWidth  macro read data.
- mem_ready_i  in  1  bank available this cycle (0: macro busy, e.g. refresh or second port).

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values and behaviour:
  - While rst_i=1: gnt_o=0, mem_req_o=0, vld_o=0, rdata_o=0.
  - Reset clears the credit counter, the latency tag pipeline and the FIFO pointers.
  - Reset mid-operation discards in-flight reads; mem_rdata_i is ignored for MemLatency cycles after reset deasserts.
- credit_ok = (cnt < NumOutstanding).
- Grant: gnt_o = req_i & mem_ready_i & credit_ok & ~rst_i.
- Memory drive: mem_req_o = gnt_o. mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o pass through from wen_i, add_i, wdata_i and be_i unregistered.
- Request ordering: a request held without grant must stay stable (initiator rule). The block keeps no request state; grant order is issue order.
- Tag pipeline:
  - A MemLatency-deep shift register carries resp_tag = gnt_o & (~wen_i | WR_RESP), plus a we bit.
  - At the stage where tag=1, the response is pushed into the FIFO at that clock edge.
  - Pushed data is mem_rdata_i for reads and all-zero for writes.
- Response FIFO:
  - Depth NumOutstanding, 2-state registers, storage not reset.
  - vld_o = ~empty; rdata_o = head entry when vld_o=1, else 0.
  - Pop on vld_o & rsp_ready_i.
- Latency: grant in cycle T → earliest vld_o in cycle T+MemLatency+1 (no fall-through). Response order equals grant order.
- Credit counter cnt, width $clog2(NumOutstanding+1):
  - +1 on a grant with resp_tag=1; -1 on pop.
  - Both in the same cycle: unchanged.
  - Saturation is impossible by construction.
- Overflow and full conditions:
  - cnt counts pipeline entries plus FIFO entries, so the FIFO cannot overflow.
  - At cnt=NumOutstanding, gnt_o=0 even with mem_ready_i=1.
  - A pop in that cycle does not re-enable grant until the next cycle, so credit_ok is registered-count based. No combinational rsp_ready_i→gnt_o path.
- Empty/full flags derive from wrap-bit pointers; pointers wrap modulo NumOutstanding (not necessarily a power of 2).
- Writes without WR_RESP consume no credit and produce no vld.
- Assertions (translate_off):
  - Parameter ranges.
  - No push when full.
  - No pop when empty.
  - req_i and the request payload stable while req_i & ~gnt_o.

Optional Feature:
- Macro: VARLAT_BANK_WRITE_RESP_EN.
- Defined (WR_RESP=1): every granted store produces one vld_o pulse with rdata_o=0 at the same latency as a load, and consumes one credit.
- Undefined (WR_RESP=0): stores are fire-and-forget; only loads produce responses and consume credits.

Test Plan:
- Load/load: MemLatency=1, rsp_ready_i=1. Store 0xDEADBEEF @0x004 (be=4'hF), then load @0x004 → gnt_o=1 both cycles; load vld_o=1 exactly 2 cycles after its grant with rdata_o=0xDEADBEEF.
- Byte enables: store 0x11223344 with be=4'b0101 onto 0xFFFFFFFF, then load → rdata_o=0xFF22FF44.
- Credit exhaustion: NumOutstanding=4, rsp_ready_i=0, 6 back-to-back loads → 4 granted, gnt_o=0 from the 5th; raise rsp_ready_i → 4 responses in order, then the 5th is granted the cycle after cnt drops to 3.
- Bank stall: mem_ready_i=0 for 3 cycles with req_i=1 → gnt_o=0 and mem_req_o=0 for those 3 cycles; grant in the 4th, with no duplicate access.
- Simultaneous push/pop: continuous loads with rsp_ready_i=1, MemLatency=2 → one grant and one vld every cycle in steady state; cnt constant at 3.
- Reset and macro: assert rst_i for 1 cycle with 2 reads in flight → vld_o=0 afterwards and no stale response appears. With VARLAT_BANK_WRITE_RESP_EN, a store yields vld_o=1, rdata_o=0; without it, a store yields no vld.
